// File: rtl/mult_seq_control_if.sv
// rtl/mult_seq_control_if.sv - control/strobe bundle between sequencer and datapath
interface mult_seq_control_if #(
   parameter int CNT_W = 3
);
   logic             Execute;
   logic             ClearXA_LoadB;
   logic             M;
   logic             Clr_XA;
   logic             Ld_B;
   logic             Ld_XA;
   logic             Add;
   logic             Sub;
   logic             Shift;
   logic             Busy;
   logic             Done;
   logic [CNT_W-1:0] Iter;

   modport master (
      output Execute, ClearXA_LoadB, M,
      input  Clr_XA, Ld_B, Ld_XA, Add, Sub, Shift, Busy, Done, Iter
   );

   modport slave (
      input  Execute, ClearXA_LoadB, M,
      output Clr_XA, Ld_B, Ld_XA, Add, Sub, Shift, Busy, Done, Iter
   );
endinterface

// File: rtl/mult_seq_control.sv
// rtl/mult_seq_control.sv - sequencing FSM for the shift-add signed multiplier
module mult_seq_control #(
   parameter int N_BITS = 8,
   parameter int CNT_W  = 3
) (
   input  logic               Clk,
   input  logic               Reset,
   mult_seq_control_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_ADD,
      S_SHIFT,
      S_SUB,
      S_LSHIFT,
      S_HOLD
   } state_t;

   // Iteration index of the shift that hands over to the sign-correction step
   localparam logic [CNT_W-1:0] LAST_ADD_ITER = CNT_W'(N_BITS - 2);

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] iter;

   logic clr_xa_c;
   logic ld_b_c;
   logic ld_xa_c;
   logic add_c;
   logic sub_c;
   logic shift_c;
   logic busy_c;
   logic done_c;

   // State register; reset aborts any run immediately
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Iteration counter: cleared at the start of a run, bumped on every non-final shift
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         iter <= '0;
      end else if (state == S_CLR) begin
         iter <= '0;
      end else if (state == S_SHIFT) begin
         iter <= iter + CNT_W'(1);
      end
   end

   // Next-state and strobe decode; everything is held low while Reset is high
   always_comb begin
      next_state = state;
      clr_xa_c   = 1'b0;
      ld_b_c     = 1'b0;
      ld_xa_c    = 1'b0;
      add_c      = 1'b0;
      sub_c      = 1'b0;
      shift_c    = 1'b0;
      busy_c     = 1'b0;
      done_c     = 1'b0;

      case (state)
         S_IDLE: begin
            // A start request wins over a simultaneous clear/load request
            clr_xa_c = bus.ClearXA_LoadB & ~bus.Execute;
            ld_b_c   = bus.ClearXA_LoadB & ~bus.Execute;
            if (bus.Execute) begin
               next_state = S_CLR;
            end
         end
         S_CLR: begin
            clr_xa_c   = 1'b1;
            busy_c     = 1'b1;
            next_state = S_ADD;
         end
         S_ADD: begin
            add_c      = 1'b1;
            ld_xa_c    = bus.M;
            busy_c     = 1'b1;
            next_state = S_SHIFT;
         end
         S_SHIFT: begin
            shift_c    = 1'b1;
            busy_c     = 1'b1;
            next_state = (iter == LAST_ADD_ITER) ? S_SUB : S_ADD;
         end
         S_SUB: begin
            // Final multiplier bit carries negative weight, so subtract instead of add
            sub_c      = 1'b1;
            ld_xa_c    = bus.M;
            busy_c     = 1'b1;
            next_state = S_LSHIFT;
         end
         S_LSHIFT: begin
            shift_c    = 1'b1;
            busy_c     = 1'b1;
            next_state = S_HOLD;
         end
         S_HOLD: begin
            // Wait for the button to be released so one press gives one multiply
            done_c = 1'b1;
            if (!bus.Execute) begin
               next_state = S_IDLE;
            end
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase

      if (Reset) begin
         clr_xa_c = 1'b0;
         ld_b_c   = 1'b0;
         ld_xa_c  = 1'b0;
         add_c    = 1'b0;
         sub_c    = 1'b0;
         shift_c  = 1'b0;
         busy_c   = 1'b0;
         done_c   = 1'b0;
      end
   end

   assign bus.Clr_XA = clr_xa_c;
   assign bus.Ld_B   = ld_b_c;
   assign bus.Ld_XA  = ld_xa_c;
   assign bus.Add    = add_c;
   assign bus.Sub    = sub_c;
   assign bus.Shift  = shift_c;
   assign bus.Busy   = busy_c;
   assign bus.Done   = done_c;
   assign bus.Iter   = iter;

endmodule

// File: tb/tb_mult_seq_control.sv
// tb/tb_mult_seq_control.sv - scoreboard bench for the multiplier sequencer
module tb_mult_seq_control;

   logic clk;
   logic rst;

   mult_seq_control_if #(.CNT_W(3)) bus ();

   mult_seq_control #(
      .N_BITS (8),
      .CNT_W  (3)
   ) dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   typedef struct {
      logic [10:0] v;
      string       nm;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   exp_iter = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Vector layout: Clr_XA Ld_B Ld_XA Add Sub Shift Busy Done Iter[2:0]
   function automatic logic [10:0] vec(input bit clr, ldb, ldxa, add, sub, sh, busy, done,
                                       input int it);
      logic [2:0] i3;
      i3 = it[2:0];
      return {clr, ldb, ldxa, add, sub, sh, busy, done, i3};
   endfunction

   // Monitor: compare every mid-cycle sample against the oldest expectation
   always @(negedge clk) begin
      exp_t        e;
      logic [10:0] act;
      if (sb.size() > 0) begin
         e   = sb.pop_front();
         act = {bus.Clr_XA, bus.Ld_B, bus.Ld_XA, bus.Add, bus.Sub, bus.Shift,
                bus.Busy, bus.Done, bus.Iter};
         checks++;
         if (act !== e.v) begin
            errors++;
            $display("FAIL %s: got %b exp %b (t=%0t)", e.nm, act, e.v, $time);
         end
      end
   end

   // Drive one cycle of inputs just after the edge and queue that cycle's expected outputs
   task automatic step(input bit r, exe, cl, m, input logic [10:0] e, input string nm);
      exp_t x;
      @(posedge clk);
      #1;
      rst               = r;
      bus.Execute       = exe;
      bus.ClearXA_LoadB = cl;
      bus.M             = m;
      x.v  = e;
      x.nm = nm;
      sb.push_back(x);
   endtask

   // One full multiply; mpat bit i is M for add step i, bit 7 for the subtract step
   task automatic run(input logic [7:0] mpat, input int hold_extra, input int clr_at,
                      input string tag);
      int c;
      c = 0;
      step(0, 1, c == clr_at, 0, vec(0,0,0,0,0,0,0,0,exp_iter), {tag, "_start"}); c++;
      step(0, 1, c == clr_at, 0, vec(1,0,0,0,0,0,1,0,exp_iter), {tag, "_clr"}); c++;
      exp_iter = 0;
      for (int i = 0; i < 7; i++) begin
         step(0, 1, c == clr_at, mpat[i], vec(0,0,mpat[i],1,0,0,1,0,i), {tag, "_add"}); c++;
         step(0, 1, c == clr_at, mpat[i], vec(0,0,0,0,0,1,1,0,i), {tag, "_shift"}); c++;
      end
      step(0, 1, c == clr_at, mpat[7], vec(0,0,mpat[7],0,1,0,1,0,7), {tag, "_sub"}); c++;
      step(0, 1, c == clr_at, mpat[7], vec(0,0,0,0,0,1,1,0,7), {tag, "_lshift"}); c++;
      for (int i = 0; i <= hold_extra; i++) begin
         step(0, 1, 0, 0, vec(0,0,0,0,0,0,0,1,7), {tag, "_hold"});
      end
      step(0, 0, 0, 0, vec(0,0,0,0,0,0,0,1,7), {tag, "_release"});
      step(0, 0, 0, 0, vec(0,0,0,0,0,0,0,0,7), {tag, "_idle"});
      exp_iter = 7;
   endtask

   initial begin
      rst               = 1'b1;
      bus.Execute       = 1'b0;
      bus.ClearXA_LoadB = 1'b0;
      bus.M             = 1'b0;

      // Reset state, then release with no request
      step(1, 0, 1, 0, vec(0,0,0,0,0,0,0,0,0), "reset_hold");
      step(1, 1, 0, 0, vec(0,0,0,0,0,0,0,0,0), "reset_exec_ignored");
      step(0, 0, 0, 0, vec(0,0,0,0,0,0,0,0,0), "reset_release");
      step(0, 0, 0, 0, vec(0,0,0,0,0,0,0,0,0), "idle_quiet");

      // Clear/load pulse in IDLE is a same-cycle strobe
      step(0, 0, 1, 0, vec(1,1,0,0,0,0,0,0,0), "idle_clrld");
      step(0, 0, 0, 0, vec(0,0,0,0,0,0,0,0,0), "idle_clrld_off");

      // Execute together with clear/load: clear/load suppressed, run starts
      run(8'hFF, 0, 0, "m1_prio");
      run(8'h00, 0, -1, "m0");
      run(8'hA5, 40, -1, "mpat_longhold");
      run(8'h5A, 0, 10, "clrld_midrun");

      // Async reset mid-run
      step(0, 1, 0, 0, vec(0,0,0,0,0,0,0,0,exp_iter), "abort_start");
      step(0, 1, 0, 0, vec(1,0,0,0,0,0,1,0,exp_iter), "abort_clr");
      exp_iter = 0;
      step(0, 1, 0, 1, vec(0,0,1,1,0,0,1,0,0), "abort_add0");
      step(0, 1, 0, 1, vec(0,0,0,0,0,1,1,0,0), "abort_shift0");
      step(0, 1, 0, 1, vec(0,0,1,1,0,0,1,0,1), "abort_add1");
      step(1, 1, 1, 1, vec(0,0,0,0,0,0,0,0,0), "abort_rst_async");
      step(1, 1, 0, 1, vec(0,0,0,0,0,0,0,0,0), "abort_rst_hold");
      step(0, 0, 0, 0, vec(0,0,0,0,0,0,0,0,0), "abort_released");
      step(0, 0, 0, 0, vec(0,0,0,0,0,0,0,0,0), "abort_idle");

      // Fresh run after abort must start cleanly from CLR
      run(8'h81, 0, -1, "after_abort");

      @(posedge clk);
      @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending exp 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_seq_control.md
Name: mult_seq_control

Overview:
- Sequencing FSM for the 8-bit shift-add signed multiplier datapath: X flip-flop, A/B shift registers, 9-bit add/sub adder.
- Turns the synchronized Execute and ClearXA_LoadB buttons into per-cycle control strobes.
- Controls: clear X/A, load B, conditional add or subtract into XA, arithmetic shift of XA:B.
- Runs one N-bit multiply per Execute press. Sits between the button synchronizers and the datapath registers.

Parameters:
N_BITS, 8, multiplier width = number of add/shift iterations (must be >= 2).
CNT_W, 3, counter width, equal to clog2(N_BITS).

Ports:
Clk  in  1  system clock, all state on rising edge.
Reset  in  1  asynchronous, active-high reset (synchronized button).
Execute  in  1  synchronized, active-high start request (level).
ClearXA_LoadB  in  1  synchronized, active-high clear X/A and load B from switches.
M  in  1  current multiplier LSB (B[0]).
Clr_XA  out  1  clear X and A this cycle.
Ld_B  out  1  load B from switch data this cycle.
Ld_XA  out  1  load adder result into X and A this cycle.
Add  out  1  adder in add mode.
Sub  out  1  adder in subtract mode (two's-complement of S).
Shift  out  1  arithmetic right shift of X->A->B this cycle.
Busy  out  1  multiply sequence in progress (CLR through final SHIFT).
Done  out  1  result valid, sequence finished, waiting for Execute release.
Iter  out  CNT_W  current iteration index 0..N_BITS-1.

Behaviour:
- Reset is asynchronous and active-high, forcing the FSM to IDLE and Iter to 0. While Reset = 1, every output is 0, including Clr_XA and Ld_B.
- States: IDLE, CLR, ADD, SHIFT, SUB, LSHIFT, HOLD.
- IDLE transitions:
  - Execute = 1 -> CLR.
  - Else stay in IDLE.
  - Execute has priority over ClearXA_LoadB in the same cycle; ClearXA_LoadB is then ignored.
- IDLE outputs: Clr_XA = Ld_B = ClearXA_LoadB & ~Execute (combinational, same cycle). All other outputs 0.
- CLR: Clr_XA = 1, Busy = 1, Iter <= 0. Next state ADD.
- ADD: Add = 1, Ld_XA = M, Busy = 1. Next state SHIFT.
- SHIFT: Shift = 1, Busy = 1, Iter <= Iter + 1.
  - Next state SUB if Iter == N_BITS-2, else ADD.
- SUB: Sub = 1, Ld_XA = M, Busy = 1. Next state LSHIFT.
  - This is the sign-correction step for the final multiplier bit.
- LSHIFT: Shift = 1, Busy = 1. Next state HOLD.
- HOLD: Done = 1.
  - Next state IDLE when Execute = 0, else stay in HOLD.
  - A held button never starts a second multiply.
- Ld_XA is Mealy (depends on M). All other strobes are Moore (state only).
- Add and Sub are never both 1. Ld_XA and Shift are never both 1. Ld_XA is 0 outside ADD/SUB.
- Latency:
  - Execute seen in IDLE -> CLR on the next cycle.
  - Total Busy duration = 1 + 2*N_BITS cycles (17 for N_BITS = 8).
  - Done rises the cycle after LSHIFT.
  - Exactly N_BITS Shift pulses and N_BITS-1 Add-state cycles per run.
- Iter wraps never; it is held at N_BITS-1 through SUB/LSHIFT/HOLD and cleared in CLR.
- ClearXA_LoadB outside IDLE is ignored. No Clr_XA or Ld_B mid-run.
- Execute dropping mid-run does not abort; the sequence completes, then HOLD exits to IDLE on the next cycle.
- Reset mid-run aborts immediately. Datapath contents are undefined; the next Execute restarts from CLR.

Test Plan:
- Reset asserted between edges -> all outputs 0 and Iter = 0 before the next edge. Release with Execute = 0 -> FSM remains IDLE, Busy = 0.
- IDLE, ClearXA_LoadB = 1 for 1 cycle, Execute = 0 -> Clr_XA = Ld_B = 1 that cycle only. Same stimulus with Execute = 1 -> Clr_XA = Ld_B = 0, FSM enters CLR.
- Execute held, M = 1 constant:
  - Clr_XA on cycle 1.
  - Cycles 2..15 alternate Add+Ld_XA / Shift (7 pairs).
  - Cycle 16 Sub+Ld_XA, cycle 17 Shift.
  - Done = 1 from cycle 18 onward.
  - Shift count = 8, Busy high for exactly 17 cycles.
- Execute held, M = 0 constant -> same state sequence with Add/Sub strobes present, but Ld_XA never asserted.
- Execute held 40 cycles after Done -> stays in HOLD, no second CLR. Release -> IDLE next cycle. Second press -> full 17-cycle run again.
- Reset pulse at cycle 6 of a run -> outputs 0 asynchronously, IDLE after release. ClearXA_LoadB pulse at cycle 10 of an unreset run -> no Clr_XA/Ld_B, and the run completes normally.
